// File: rtl/pwm_sine_pkg.sv
// Shared constants for the PWM sinewave block: quarter-wave sine table,
// phase width default, duty reset value and the quadrant encoding.
`timescale 1ns/1ps
package pwm_sine_pkg;

  localparam int PHASE_BITS_DEF = 14;
  localparam logic [7:0] DUTY_RESET = 8'd128;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  // round(127*sin(2*pi*k/256)) for k = 0..64
  localparam logic [6:0] Q_TABLE [65] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

endpackage

// File: rtl/pwm_sine_lut.sv
// Combinational sine lookup: folds an 8-bit phase index onto the
// quarter-wave table and offsets it around mid-scale (128).
`timescale 1ns/1ps
module pwm_sine_lut
  import pwm_sine_pkg::*;
(
  input  logic [7:0] idx_i,
  output logic [7:0] sample_o
);

  quadrant_e  quad;
  logic [6:0] fold_idx;
  logic [6:0] mag;

  always_comb begin
    quad     = quadrant_e'(idx_i[7:6]);
    fold_idx = {1'b0, idx_i[5:0]};
    // Odd quadrants walk the table backwards, so the peak lands on entry 64.
    if (quad == Q1 || quad == Q3) begin
      fold_idx = 7'd64 - {1'b0, idx_i[5:0]};
    end
    mag = Q_TABLE[fold_idx];
    case (quad)
      Q0, Q1:  sample_o = DUTY_RESET + {1'b0, mag};
      default: sample_o = DUTY_RESET - {1'b0, mag};
    endcase
  end

endmodule

// File: rtl/pwm_sinewave_example.sv
// Sinewave PWM generator: phase accumulator steps once per 256-clock period
// and the looked-up sample sets the next period's duty. Define SAMPLE_OUT_EN
// to drive the registered duty onto uio_out with all uio pins enabled.
`timescale 1ns/1ps
module pwm_sinewave_example
  import pwm_sine_pkg::*;
#(
  parameter int PHASE_BITS = PHASE_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0]            cnt_q, cnt_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [7:0]            duty_q, duty_d;
  logic                  pwm_q, pwm_d;
  logic                  pwm_n_q, pwm_n_d;
  logic                  strobe_q, strobe_d;

  logic [PHASE_BITS-1:0] phase_next;
  logic [7:0]            sample;
  logic                  period_end;
  logic                  duty_lt;
  logic                  unused_ok;

  assign unused_ok  = &{1'b0, uio_in};
  assign period_end = ena && (cnt_q == 8'hFF);
  assign phase_next = phase_q + {{(PHASE_BITS-8){1'b0}}, ui_in};

  // Table lookup uses the phase being committed this edge, not the old one.
  pwm_sine_lut u_lut (
    .idx_i    (phase_next[PHASE_BITS-1 -: 8]),
    .sample_o (sample)
  );

  always_comb begin
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    duty_d   = duty_q;
    duty_lt  = (cnt_q < duty_q);
    pwm_d    = ena & duty_lt;
    pwm_n_d  = ena & ~duty_lt;
    strobe_d = period_end;
    if (ena) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (period_end) begin
      phase_d = phase_next;
      duty_d  = sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      phase_q  <= '0;
      duty_q   <= DUTY_RESET;
      pwm_q    <= 1'b0;
      pwm_n_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      pwm_n_q  <= pwm_n_d;
      strobe_q <= strobe_d;
    end
  end

  assign uo_out = {duty_q[7:3], strobe_q, pwm_n_q, pwm_q};

`ifdef SAMPLE_OUT_EN
  assign uio_out = duty_q;
  assign uio_oe  = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_pwm_sinewave_example.sv
// Bench for pwm_sinewave_example: period-level reference model built from
// floating-point sine and modular phase arithmetic.
`timescale 1ns/1ps
module tb_pwm_sinewave_example;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;
  int exp_phase;
  int exp_duty;

  pwm_sinewave_example dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // sine(i) = 128 +/- round(127*sin(2*pi*k/256)) with quarter-wave folding
  function automatic int sine_ref(input int i);
    real pi;
    int  m, a, q;
    pi = 3.14159265358979323846;
    m  = i % 128;
    a  = (m <= 64) ? m : 128 - m;
    q  = $rtoi(127.0 * $sin(2.0 * pi * a / 256.0) + 0.5);
    return (i < 128) ? 128 + q : 128 - q;
  endfunction

  function automatic logic [7:0] exp_uio_out();
    logic [7:0] d;
    d = exp_duty[7:0];
`ifdef SAMPLE_OUT_EN
    return d;
`else
    return 8'h00 & d;
`endif
  endfunction

  function automatic logic [7:0] exp_uio_oe();
`ifdef SAMPLE_OUT_EN
    return 8'hFF;
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_reset();
    exp_phase = 0;
    exp_duty  = 128;
  endtask

  task automatic model_period_end();
    exp_phase = (exp_phase + int'(ui_in)) % 16384;
    exp_duty  = sine_ref(exp_phase / 64);
  endtask

  // One PWM period of 256 enabled clocks, optionally with ena dropped for
  // gate_len clocks after gate_at enabled clocks. Starts and ends on negedge.
  task automatic run_window(input string tag, input int gate_at, input int gate_len,
                            output int highs);
    int         edges, gated, strobe_err, comp_err, gate_err, hold_err;
    logic       en;
    logic [4:0] duty_field;
    edges = 0; gated = 0; strobe_err = 0; comp_err = 0; gate_err = 0; hold_err = 0;
    highs = 0;
    duty_field = uo_out[7:3];
    while (edges < 256) begin
      en  = !(gate_len > 0 && edges == gate_at && gated < gate_len);
      ena = en;
      @(posedge clk);
      @(negedge clk);
      if (en) begin
        edges++;
        if (uo_out[0] === 1'b1) highs++;
        if (uo_out[1] !== ~uo_out[0]) comp_err++;
        if (uo_out[2] !== (edges == 256)) strobe_err++;
      end else begin
        gated++;
        if (uo_out[2:0] !== 3'b000) gate_err++;
        if (uo_out[7:3] !== duty_field) hold_err++;
      end
    end
    ena = 1'b1;

    checks++;
    if (highs !== exp_duty) begin
      failures++;
      $display("FAIL %s high_clocks: got %0d expected %0d", tag, highs, exp_duty);
    end
    checks++;
    if (strobe_err !== 0) begin
      failures++;
      $display("FAIL %s strobe_position: got %0d bad samples expected 0", tag, strobe_err);
    end
    checks++;
    if (comp_err !== 0) begin
      failures++;
      $display("FAIL %s pwm_n_complement: got %0d bad samples expected 0", tag, comp_err);
    end
    if (gate_len > 0) begin
      checks++;
      if (gate_err !== 0) begin
        failures++;
        $display("FAIL %s gated_outputs: got %0d nonzero samples expected 0", tag, gate_err);
      end
      checks++;
      if (hold_err !== 0) begin
        failures++;
        $display("FAIL %s gated_duty_hold: got %0d changed samples expected 0", tag, hold_err);
      end
    end

    model_period_end();
    checks++;
    if (uo_out[7:3] !== exp_duty[7:3]) begin
      failures++;
      $display("FAIL %s next_duty_field: got %0d expected %0d", tag, uo_out[7:3], exp_duty[7:3]);
    end
    checks++;
    if (uio_out !== exp_uio_out() || uio_oe !== exp_uio_oe()) begin
      failures++;
      $display("FAIL %s uio_bus: got out=%h oe=%h expected out=%h oe=%h",
               tag, uio_out, uio_oe, exp_uio_out(), exp_uio_oe());
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (uo_out !== 8'h80) begin
      failures++;
      $display("FAIL %s uo_out: got %h expected 80", tag, uo_out);
    end
    checks++;
    if (uio_out !== exp_uio_out() || uio_oe !== exp_uio_oe()) begin
      failures++;
      $display("FAIL %s uio_bus: got out=%h oe=%h expected out=%h oe=%h",
               tag, uio_out, uio_oe, exp_uio_out(), exp_uio_oe());
    end
  endtask

  task automatic test_reset();
    int highs;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) run_window("reset_period", 0, 0, highs);
  endtask

  task automatic test_constant();
    int highs;
    ui_in = 8'd0;
    for (int p = 0; p < 8; p++) begin
      uio_in = 8'($urandom);
      run_window("constant", 0, 0, highs);
    end
  endtask

  task automatic test_sweep();
    int highs;
    ui_in = 8'd64;
    for (int p = 0; p <= 192; p++) begin
      uio_in = 8'($urandom);
      run_window("sweep", 0, 0, highs);
      if (p == 64) begin
        checks++;
        if (highs !== 255) begin
          failures++;
          $display("FAIL sweep_peak: got %0d high clocks expected 255", highs);
        end
      end else if (p == 128) begin
        checks++;
        if (highs !== 128) begin
          failures++;
          $display("FAIL sweep_mid: got %0d high clocks expected 128", highs);
        end
      end else if (p == 192) begin
        checks++;
        if (highs !== 1) begin
          failures++;
          $display("FAIL sweep_trough: got %0d high clocks expected 1", highs);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    int highs;
    for (int p = 0; p < 3; p++) begin
      ui_in = 8'($urandom_range(1, 255));
      run_window("enable_gating", $urandom_range(5, 250), 40, highs);
    end
  endtask

  task automatic test_random();
    int highs;
    for (int p = 0; p < 8; p++) begin
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        run_window("random_gated", $urandom_range(0, 255), $urandom_range(1, 60), highs);
      else
        run_window("random", 0, 0, highs);
    end
  endtask

  task automatic test_async_reset();
    int highs;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ui_in = 8'd200;
    for (int p = 0; p < 10; p++) run_window("pre_async", 0, 0, highs);
    repeat ($urandom_range(20, 200)) @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    check_reset_values("async_reset_hold");
    ui_in = 8'd0;
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) run_window("restart", 0, 0, highs);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    model_reset();
    test_reset();
    test_constant();
    test_sweep();
    test_enable_gating();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
